// File: rtl/mbscore_pkg.sv
// rtl/mbscore_pkg.sv - shared MBScore core constants: widths, fetch states, NOP
package mbscore_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP = 32'h0000_0000;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/mbscore_fetch_buf.sv
// rtl/mbscore_fetch_buf.sv - one-entry fetch buffer: tag/data/valid with hit compare
module mbscore_fetch_buf
  import mbscore_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] lookup_addr_i,
  input  logic          inval_i,
  input  logic          load_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [DW-1:0] load_data_i,
  output logic          hit_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q;
  logic [AW-1:0] tag_q;
  logic [DW-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      // A data-memory write may have changed the buffered word, so inval beats a load
      if (inval_i)     valid_q <= 1'b0;
      else if (load_i) valid_q <= 1'b1;
      if (load_i) begin
        tag_q  <= load_addr_i;
        data_q <= load_data_i;
      end
    end
  end

  assign hit_o  = valid_q & (tag_q == lookup_addr_i) & ~inval_i;
  assign data_o = data_q;

endmodule

// File: rtl/mbscore_ifetch.sv
// rtl/mbscore_ifetch.sv - instruction fetch FSM, wait counter and instruction register
module mbscore_ifetch
  import mbscore_pkg::*;
#(
  parameter int DATA_WIDTH = mbscore_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = mbscore_pkg::ADDR_WIDTH,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ir_ack,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  flush,
  input  logic                  inval,
  output logic                  ibus_req,
  output logic [ADDR_WIDTH-1:0] ibus_addr,
  input  logic [DATA_WIDTH-1:0] ibus_rdata,
  input  logic                  ibus_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic                  inst_valid,
  output logic                  stall,
  output logic                  fetch_err
);

  localparam logic [7:0]            TIMEOUT_CNT = 8'(TIMEOUT);
  localparam logic [DATA_WIDTH-1:0] NOP_WORD    = DATA_WIDTH'(NOP);

  fetch_state_e          state_q;
  logic [7:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  req_q;
  logic [DATA_WIDTH-1:0] inst_q;
  logic                  inst_valid_q;
  logic                  err_q;

  logic                  hit;
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  aligned;
  logic                  buf_load;

  assign aligned  = word_aligned(pc[1:0]);
  assign buf_load = (state_q == S_REQ) & ~flush & ibus_ready;

  mbscore_fetch_buf #(
    .DW(DATA_WIDTH),
    .AW(ADDR_WIDTH)
  ) u_fetch_buf (
    .clk          (clk),
    .rst          (rst),
    .lookup_addr_i(pc),
    .inval_i      (inval),
    .load_i       (buf_load),
    .load_addr_i  (addr_q),
    .load_data_i  (ibus_rdata),
    .hit_o        (hit),
    .data_o       (buf_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      req_q        <= 1'b0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      inst_valid_q <= 1'b0;
      err_q        <= 1'b0;
      if (flush) begin
        state_q <= S_IDLE;
        req_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (ir_ack) begin
              if (!aligned) begin
                inst_q       <= NOP_WORD;
                inst_valid_q <= 1'b1;
                err_q        <= 1'b1;
              end else if (hit) begin
                inst_q       <= buf_data;
                inst_valid_q <= 1'b1;
              end else begin
                addr_q  <= pc;
                req_q   <= 1'b1;
                cnt_q   <= '0;
                state_q <= S_REQ;
              end
            end
          end
          S_REQ: begin
            if (ibus_ready) begin
              inst_q       <= ibus_rdata;
              inst_valid_q <= 1'b1;
              req_q        <= 1'b0;
              state_q      <= S_IDLE;
            end else if (cnt_q == TIMEOUT_CNT) begin
              // Bus never answered: hand decode a NOP and flag the error
              inst_q       <= NOP_WORD;
              inst_valid_q <= 1'b1;
              err_q        <= 1'b1;
              req_q        <= 1'b0;
              state_q      <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign stall = (state_q == S_REQ) |
                 ((state_q == S_IDLE) & ir_ack & ~hit & aligned);

  assign ibus_req   = req_q;
  assign ibus_addr  = addr_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign fetch_err  = err_q;

endmodule

// File: tb/tb_mbscore_ifetch.sv
// tb/tb_mbscore_ifetch.sv - directed self-checking bench for mbscore_ifetch
module tb_mbscore_ifetch;

  logic        clk;
  logic        rst;
  logic        ir_ack;
  logic [31:0] pc;
  logic        flush;
  logic        inval;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic [31:0] ibus_rdata;
  logic        ibus_ready;
  logic [31:0] inst;
  logic        inst_valid;
  logic        stall;
  logic        fetch_err;

  int tests;
  int fails;

  int req_n, stall_n, valid_n, err_n, valid_cyc, err_cyc;
  logic addr_ok;

  mbscore_ifetch #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .TIMEOUT   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ir_ack    (ir_ack),
    .pc        (pc),
    .flush     (flush),
    .inval     (inval),
    .ibus_req  (ibus_req),
    .ibus_addr (ibus_addr),
    .ibus_rdata(ibus_rdata),
    .ibus_ready(ibus_ready),
    .inst      (inst),
    .inst_valid(inst_valid),
    .stall     (stall),
    .fetch_err (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one fetch at cycle 0 and a bus that answers on the ready_after-th
  // request cycle (0 = never); flush_at < 0 disables flush.
  task automatic do_fetch(input logic [31:0] fpc, input logic [31:0] data,
                          input int ready_after, input int flush_at, input int ncyc);
    req_n = 0; stall_n = 0; valid_n = 0; err_n = 0;
    valid_cyc = -1; err_cyc = -1; addr_ok = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      ir_ack     = (c == 0);
      pc         = fpc;
      flush      = (c == flush_at);
      ibus_ready = ibus_req && (ready_after > 0) && (req_n == ready_after - 1);
      ibus_rdata = ibus_ready ? data : 32'hDEAD_BEEF;
      #1;
      if (stall) stall_n++;
      if (ibus_req) begin
        req_n++;
        if (ibus_addr !== fpc) addr_ok = 1'b0;
      end
      if (inst_valid) begin valid_n++; valid_cyc = c; end
      if (fetch_err) begin err_n++; err_cyc = c; end
      next_cycle();
    end
    ir_ack = 1'b0; flush = 1'b0; ibus_ready = 1'b0;
  endtask

  task automatic test_reset();
    tests++;
    if ({ibus_req, inst_valid, fetch_err, stall} !== 4'b0000) begin
      fails++; $display("FAIL reset_ctrl: got %b want 0000", {ibus_req, inst_valid, fetch_err, stall});
    end
    tests++;
    if (inst !== 32'h0 || ibus_addr !== 32'h0) begin
      fails++; $display("FAIL reset_data: inst=%h addr=%h want 0/0", inst, ibus_addr);
    end
  endtask

  task automatic test_miss();
    do_fetch(32'h10, 32'h2008_0005, 3, -1, 8);
    tests++;
    if (req_n != 3 || !addr_ok) begin
      fails++; $display("FAIL miss_req: req cycles=%0d addr_ok=%b want 3/1", req_n, addr_ok);
    end
    tests++;
    if (stall_n != 4) begin fails++; $display("FAIL miss_stall: got %0d want 4", stall_n); end
    tests++;
    if (valid_n != 1 || valid_cyc != 4) begin
      fails++; $display("FAIL miss_valid: count=%0d cycle=%0d want 1/4", valid_n, valid_cyc);
    end
    tests++;
    if (inst !== 32'h2008_0005) begin fails++; $display("FAIL miss_inst: got %h want 20080005", inst); end
  endtask

  task automatic test_hit();
    do_fetch(32'h10, 32'h1111_1111, 1, -1, 4);
    tests++;
    if (req_n != 0 || stall_n != 0) begin
      fails++; $display("FAIL hit_bus: req=%0d stall=%0d want 0/0", req_n, stall_n);
    end
    tests++;
    if (valid_n != 1 || valid_cyc != 1 || inst !== 32'h2008_0005) begin
      fails++; $display("FAIL hit_inst: valid=%0d@%0d inst=%h want 1@1 20080005", valid_n, valid_cyc, inst);
    end
  endtask

  task automatic test_inval();
    inval = 1'b1;
    next_cycle();
    inval = 1'b0;
    do_fetch(32'h10, 32'h1234_5678, 1, -1, 4);
    tests++;
    if (req_n != 1 || inst !== 32'h1234_5678) begin
      fails++; $display("FAIL inval_refetch: req=%0d inst=%h want 1 12345678", req_n, inst);
    end
  endtask

  task automatic test_misalign();
    do_fetch(32'h13, 32'h5555_5555, 1, -1, 3);
    tests++;
    if (req_n != 0 || stall_n != 0) begin
      fails++; $display("FAIL misalign_bus: req=%0d stall=%0d want 0/0", req_n, stall_n);
    end
    tests++;
    if (err_n != 1 || valid_n != 1 || err_cyc != 1 || valid_cyc != 1 || inst !== 32'h0) begin
      fails++; $display("FAIL misalign_err: err=%0d@%0d valid=%0d@%0d inst=%h want 1@1 1@1 0",
                        err_n, err_cyc, valid_n, valid_cyc, inst);
    end
  endtask

  task automatic test_timeout();
    do_fetch(32'h20, 32'h7777_7777, 0, -1, 10);
    tests++;
    if (req_n != 5 || stall_n != 6) begin
      fails++; $display("FAIL timeout_req: req=%0d stall=%0d want 5/6", req_n, stall_n);
    end
    tests++;
    if (err_n != 1 || err_cyc != 6 || valid_cyc != 6 || inst !== 32'h0) begin
      fails++; $display("FAIL timeout_err: err=%0d@%0d valid@%0d inst=%h want 1@6 @6 0",
                        err_n, err_cyc, valid_cyc, inst);
    end
    do_fetch(32'h20, 32'hAAAA_5555, 1, -1, 4);
    tests++;
    if (req_n != 1 || inst !== 32'hAAAA_5555) begin
      fails++; $display("FAIL timeout_remiss: req=%0d inst=%h want 1 aaaa5555", req_n, inst);
    end
  endtask

  task automatic test_flush();
    do_fetch(32'h30, 32'h9999_0000, 2, 2, 6);
    tests++;
    if (req_n != 2 || valid_n != 0 || inst !== 32'hAAAA_5555) begin
      fails++; $display("FAIL flush: req=%0d valid=%0d inst=%h want 2 0 aaaa5555", req_n, valid_n, inst);
    end
    do_fetch(32'h30, 32'h3333_0000, 1, -1, 4);
    tests++;
    if (req_n != 1 || inst !== 32'h3333_0000) begin
      fails++; $display("FAIL flush_noload: req=%0d inst=%h want 1 33330000", req_n, inst);
    end
  endtask

  task automatic test_reset_mid_req();
    ir_ack = 1'b1; pc = 32'h40;
    next_cycle();
    ir_ack = 1'b0;
    next_cycle();
    tests++;
    if (ibus_req !== 1'b1) begin fails++; $display("FAIL rst_pre: ibus_req=%b want 1", ibus_req); end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({ibus_req, inst_valid, fetch_err, stall} !== 4'b0000 || inst !== 32'h0 || ibus_addr !== 32'h0) begin
      fails++; $display("FAIL rst_async: ctrl=%b inst=%h addr=%h want 0000 0 0",
                        {ibus_req, inst_valid, fetch_err, stall}, inst, ibus_addr);
    end
    next_cycle();
    rst = 1'b0;
    next_cycle();
    do_fetch(32'h20, 32'h4444_0000, 1, -1, 4);
    tests++;
    if (req_n != 1 || inst !== 32'h4444_0000) begin
      fails++; $display("FAIL rst_bufclear: req=%0d inst=%h want 1 44440000", req_n, inst);
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; ir_ack = 1'b0; pc = '0; flush = 1'b0; inval = 1'b0;
    ibus_rdata = '0; ibus_ready = 1'b0;
    next_cycle();
    next_cycle();
    test_reset();
    rst = 1'b0;
    next_cycle();
    test_miss();
    test_hit();
    test_inval();
    test_misalign();
    test_timeout();
    test_flush();
    test_reset_mid_req();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/mbscore_ifetch.md
# mbscore_ifetch

Instruction-fetch unit and instruction register for the multi-cycle MBScore core. Sits directly upstream of the core control FSM. On each fetch request from the control FSM's IF state, it reads one word from the instruction bus at the current PC and loads it into the instruction register. It holds that value stable through ID/EXE/WB, and stalls the core while the bus is slow. A one-entry fetch buffer lets tight loops on the same address skip the bus.

## Interface
- DATA_WIDTH, 32, instruction/bus data width
- ADDR_WIDTH, 32, PC and bus address width
- TIMEOUT, 255, max bus wait cycles before a fetch error (8-bit counter)
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- ir_ack  in  1  fetch request from control FSM (high during IF)
- pc  in  ADDR_WIDTH  address to fetch, sampled with ir_ack
- flush  in  1  abort any fetch in progress (core stop)
- inval  in  1  invalidate fetch buffer (data-memory write strobe)
- ibus_req  out  1  instruction bus request
- ibus_addr  out  ADDR_WIDTH  instruction bus address
- ibus_rdata  in  DATA_WIDTH  instruction bus read data
- ibus_ready  in  1  read data valid this cycle
- inst  out  DATA_WIDTH  instruction register, feeds control FSM decode
- inst_valid  out  1  one-cycle pulse when inst has just been loaded
- stall  out  1  combinational; drives core pause while a fetch is unresolved
- fetch_err  out  1  one-cycle pulse on misalignment or bus timeout

## Operation
- States:
  - IDLE: waits for a fetch request.
  - REQ: bus transaction outstanding.
- IDLE, ir_ack=1, pc[1:0]≠0: misaligned. Next edge: inst←0 (NOP), inst_valid=1, fetch_err=1. Stay IDLE; no bus access.
- IDLE, ir_ack=1, buffer valid, tag==pc, inval=0: hit. Next edge: inst←buffer data, inst_valid=1. Stay IDLE.
- IDLE, ir_ack=1, otherwise: miss. Next edge: addr_reg←pc, ibus_req←1, wait counter←0. Go REQ.
- REQ, ibus_ready=1: on that edge:
  - inst←ibus_rdata, inst_valid=1, ibus_req←0.
  - buffer tag←addr_reg, data←ibus_rdata, valid←1.
  - Go IDLE.
- REQ, ibus_ready=0: counter++. When the counter reaches TIMEOUT: inst←0, inst_valid=1, fetch_err=1, ibus_req←0, go IDLE; the buffer is not loaded.
- flush=1 in any state: next edge → IDLE, ibus_req←0. inst, inst_valid and the buffer are unchanged. flush has priority over ibus_ready and ir_ack.
- inval=1: buffer valid←0 on the next edge. A hit check in the same cycle is treated as a miss. inval together with a completing bus read leaves the buffer invalid; inval wins.
- ir_ack while in REQ is ignored; no new request is sampled until back in IDLE.
- inst holds its last value in every cycle it is not explicitly loaded.
- stall = (state==REQ) | (state==IDLE & ir_ack & ~hit & pc[1:0]==0).
- ibus_addr = addr_reg. Both ibus_req and ibus_addr are registered outputs.

## Timing
- Reset values: inst=0, inst_valid=0, ibus_req=0, ibus_addr=0, fetch_err=0, buffer valid=0, state IDLE, counter 0.
- Reset asserted mid-fetch drops ibus_req immediately (asynchronous).
- Hit latency: ir_ack in cycle N → inst/inst_valid in cycle N+1, stall=0 throughout.
- Miss latency: ir_ack in cycle N → ibus_req high from N+1. With ibus_ready first seen in cycle N+k (k≥1), inst is valid in N+k+1. stall is high from N to N+k inclusive.
- The bus must hold ibus_rdata valid in the cycle ibus_ready is high. ibus_addr is stable while ibus_req=1.
- Timeout: ibus_req stays high for exactly TIMEOUT+1 cycles; the error pulse follows in the next cycle.

## Structure
- State encodings (IDLE, REQ) and the NOP constant (0) go in the shared core constants include alongside the other core opcode and state defines. DATA_WIDTH/ADDR_WIDTH defaults come from there.
- One natural sub-module: mbscore_fetch_buf (tag/data/valid register with hit compare and invalidate). The FSM, counter and instruction register stay in the top.

## Test plan
- Reset, then ir_ack with pc=0x0000_0010 and the bus returning 0x2008_0005 with ready after 3 cycles → ibus_req high 3 cycles at addr 0x10, stall high 4 cycles, inst=0x2008_0005 with a single inst_valid pulse.
- Repeat ir_ack at pc=0x10 → hit: no ibus_req, inst_valid the next cycle, stall never high.
- Pulse inval, then ir_ack at pc=0x10 → bus access occurs again.
- ir_ack with pc=0x0000_0013 → fetch_err and inst_valid pulse together, inst=0, ibus_req never asserted.
- Miss with ibus_ready held low, TIMEOUT=4 → ibus_req high 5 cycles, then fetch_err, inst=0, the next fetch at the same pc misses.
- flush 2 cycles into a miss, ibus_ready high in the same cycle → back to IDLE, inst unchanged, no inst_valid. Also assert rst mid-REQ → ibus_req low immediately, all outputs at reset values.
